// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared screen and timing constants for the sprite motion blocks, plus a
// helper that sizes a modulo counter.
//   SCREEN_X_MAX / SCREEN_Y_MAX : highest legal sprite position per axis
//   FRAME_DIV_60FPS             : clk cycles per frame at 60 fps from 50 MHz
//   FRAME_DIV_SIM               : short frame period for simulation
// -----------------------------------------------------------------------------
package motion_pkg;

    localparam int SCREEN_X_MAX    = 32'sd155;
    localparam int SCREEN_Y_MAX    = 32'sd115;
    localparam int FRAME_DIV_60FPS = 32'sd833333;
    localparam int FRAME_DIV_SIM   = 32'sd10;

    // Bits needed to count 0..n-1; a modulo-1 counter still gets one bit.
    function automatic int cnt_width(input int n);
        if (n > 32'sd1) begin
            cnt_width = $clog2(n);
        end else begin
            cnt_width = 32'sd1;
        end
    endfunction

endpackage

// File: rtl/axis_pos_counter_chk.sv
// -----------------------------------------------------------------------------
// axis_pos_counter_chk
// Simulation-only checks for axis_pos_counter: legal parameter set and
// in-range internal counters / position.
//   clk, resetn : clock and reset of the checked instance
//   fdiv, sdiv  : frame and speed divider counts
//   q           : current position
// -----------------------------------------------------------------------------
module axis_pos_counter_chk #(
    parameter int WIDTH     = 8,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = 155,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 10,
    parameter int SPEED_DIV = 5,
    parameter int FW        = 4,
    parameter int SW        = 3
) (
    input logic             clk,
    input logic             resetn,
    input logic [FW-1:0]    fdiv,
    input logic [SW-1:0]    sdiv,
    input logic [WIDTH-1:0] q
);

    localparam longint POS_LIMIT = (64'sd1 <<< WIDTH) - 64'sd1;

    a_bounds_order: assert property (@(posedge clk) POS_MIN < POS_MAX);
    a_bounds_fit:   assert property (@(posedge clk) longint'(POS_MAX) <= POS_LIMIT);
    a_min_nonneg:   assert property (@(posedge clk) POS_MIN >= 32'sd0);
    a_step_min:     assert property (@(posedge clk) STEP >= 32'sd1);
    a_step_max:     assert property (@(posedge clk) STEP <= (POS_MAX - POS_MIN));
    a_fdiv_legal:   assert property (@(posedge clk) FRAME_DIV >= 32'sd1);
    a_sdiv_legal:   assert property (@(posedge clk) SPEED_DIV >= 32'sd1);

    a_fdiv_range: assert property (@(posedge clk) disable iff (!resetn)
                                   32'(fdiv) < 32'(FRAME_DIV));
    a_sdiv_range: assert property (@(posedge clk) disable iff (!resetn)
                                   32'(sdiv) < 32'(SPEED_DIV));
    a_q_range:    assert property (@(posedge clk) disable iff (!resetn)
                                   32'(q) <= 32'(POS_MAX));

endmodule

// File: rtl/axis_pos_counter_mod_n_counter.sv
// -----------------------------------------------------------------------------
// mod_n_counter
// Free-running modulo-N counter advanced by an enable strobe.
//   clk        : system clock
//   resetn     : asynchronous active-low reset, count returns to 0
//   enable     : advance by one on this clock edge
//   count      : current count, 0..N-1
//   wrap_pulse : enable & (count == N-1), i.e. this edge wraps back to 0
// -----------------------------------------------------------------------------
module mod_n_counter
    import motion_pkg::*;
#(
    parameter int N = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    output logic [cnt_width(N)-1:0] count,
    output logic                    wrap_pulse
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_last_s;

    assign at_last_s  = (count_q == LAST);
    assign wrap_pulse = enable & at_last_s;
    assign count      = count_q;

    // Next count: hold when idle, wrap after the last value.
    always_comb begin
        count_d = count_q;
        if (enable) begin
            if (at_last_s) begin
                count_d = {CW{1'b0}};
            end else begin
                count_d = count_q + CW'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_pos_counter.sv
// -----------------------------------------------------------------------------
// axis_pos_counter
// Bounded sprite position for one screen axis, stepped at a fixed cadence.
// A frame divider produces frame_tick every FRAME_DIV enabled cycles; a speed
// divider turns every SPEED_DIV-th frame tick into a step slot. On a step slot
// with move set, q moves by STEP toward updown, saturating or wrapping at the
// bounds. load overrides everything and clamps load_val into range.
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   enable     : advances the dividers, 0 freezes timing
//   move       : take a step at the next step slot
//   updown     : 1 = increment, 0 = decrement
//   load       : synchronous position load (priority over a step)
//   load_val   : value to load, clamped to [POS_MIN, POS_MAX]
//   q          : current position
//   at_min     : q == POS_MIN
//   at_max     : q == POS_MAX
//   frame_tick : one-cycle frame pulse
//   moved      : one-cycle pulse after a step actually changed q
// -----------------------------------------------------------------------------
module axis_pos_counter
    import motion_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = SCREEN_X_MAX,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = FRAME_DIV_SIM,
    parameter int SPEED_DIV = 5,
    parameter int WRAP      = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             move,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             at_min,
    output logic             at_max,
    output logic             frame_tick,
    output logic             moved
);

    localparam int FW = cnt_width(FRAME_DIV);
    localparam int SW = cnt_width(SPEED_DIV);
    localparam int XW = WIDTH + 1;

    // Position arithmetic runs one bit wider so q + STEP never overflows.
    localparam logic [XW-1:0]    MIN_X     = XW'(POS_MIN);
    localparam logic [XW-1:0]    MAX_X     = XW'(POS_MAX);
    localparam logic [XW-1:0]    STEP_X    = XW'(STEP);
    localparam logic [XW-1:0]    DEC_LIM_X = XW'(POS_MIN + STEP);
    localparam logic [WIDTH-1:0] MIN_Q     = WIDTH'(POS_MIN);
    localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(POS_MAX);

    logic [FW-1:0]    fdiv_s;
    logic [SW-1:0]    sdiv_s;
    logic             frame_tick_s;
    logic             step_slot_s;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             moved_q;
    logic             moved_d;

    logic [XW-1:0]    q_ext_s;
    logic [XW-1:0]    inc_ext_s;
    logic [XW-1:0]    dec_ext_s;
    logic [XW-1:0]    lv_ext_s;
    logic [WIDTH-1:0] step_val_s;
    logic [WIDTH-1:0] load_clamp_s;

    mod_n_counter #(
        .N (FRAME_DIV)
    ) u_frame_div (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .count      (fdiv_s),
        .wrap_pulse (frame_tick_s)
    );

    // The speed divider only advances on frame ticks, so its wrap pulse is
    // exactly frame_tick & (sdiv == SPEED_DIV-1).
    mod_n_counter #(
        .N (SPEED_DIV)
    ) u_speed_div (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (frame_tick_s),
        .count      (sdiv_s),
        .wrap_pulse (step_slot_s)
    );

    axis_pos_counter_chk #(
        .WIDTH     (WIDTH),
        .POS_MIN   (POS_MIN),
        .POS_MAX   (POS_MAX),
        .STEP      (STEP),
        .FRAME_DIV (FRAME_DIV),
        .SPEED_DIV (SPEED_DIV),
        .FW        (FW),
        .SW        (SW)
    ) u_chk (
        .clk    (clk),
        .resetn (resetn),
        .fdiv   (fdiv_s),
        .sdiv   (sdiv_s),
        .q      (q_q)
    );

    assign q_ext_s   = {1'b0, q_q};
    assign inc_ext_s = q_ext_s + STEP_X;
    assign dec_ext_s = q_ext_s - STEP_X;
    assign lv_ext_s  = {1'b0, load_val};

    // Candidate position for a step, saturating or wrapping at the bounds.
    always_comb begin
        step_val_s = q_q;
        if (updown) begin
            if (inc_ext_s <= MAX_X) begin
                step_val_s = inc_ext_s[WIDTH-1:0];
            end else if (WRAP != 0) begin
                step_val_s = MIN_Q;
            end else begin
                step_val_s = MAX_Q;
            end
        end else begin
            if (q_ext_s >= DEC_LIM_X) begin
                step_val_s = dec_ext_s[WIDTH-1:0];
            end else if (WRAP != 0) begin
                step_val_s = MAX_Q;
            end else begin
                step_val_s = MIN_Q;
            end
        end
    end

    // Clamp the load value; the equal-to-bound cases fold into the clamp.
    always_comb begin
        load_clamp_s = load_val;
        if (lv_ext_s <= MIN_X) begin
            load_clamp_s = MIN_Q;
        end else if (lv_ext_s >= MAX_X) begin
            load_clamp_s = MAX_Q;
        end else begin
            load_clamp_s = load_val;
        end
    end

    // Next position and moved flag; load wins over a step and never sets moved.
    always_comb begin
        q_d     = q_q;
        moved_d = 1'b0;
        if (load) begin
            q_d     = load_clamp_s;
            moved_d = 1'b0;
        end else if (step_slot_s && move) begin
            q_d     = step_val_s;
            moved_d = (step_val_s != q_q);
        end else begin
            q_d     = q_q;
            moved_d = 1'b0;
        end
    end

    // Position and moved registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q     <= MIN_Q;
            moved_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            moved_q <= moved_d;
        end
    end

    assign q          = q_q;
    assign moved      = moved_q;
    assign frame_tick = frame_tick_s;
    assign at_min     = (q_q == MIN_Q);
    assign at_max     = (q_q == MAX_Q);

endmodule

// File: tb/tb_axis_pos_counter.sv
// -----------------------------------------------------------------------------
// tb_axis_pos_counter
// Three instances: defaults (FRAME_DIV 10, SPEED_DIV 5, STEP 1, saturate),
// a STEP 2 saturating one and a STEP 1 wrapping one, the latter two stepping
// on every enabled cycle (FRAME_DIV = SPEED_DIV = 1).
// -----------------------------------------------------------------------------
module tb_axis_pos_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    // Default instance
    logic       d_en, d_mv, d_ud, d_ld;
    logic [7:0] d_lv, d_q;
    logic       d_amin, d_amax, d_tick, d_moved;

    // Shared stimulus for the step-every-cycle instances
    logic       t_en, t_mv, t_ud, t_ld;
    logic [7:0] t_lv;
    logic [7:0] s_q, w_q;
    logic       s_amin, s_amax, s_tick, s_moved;
    logic       w_amin, w_amax, w_tick, w_moved;

    axis_pos_counter u_dflt (
        .clk(clk), .resetn(resetn), .enable(d_en), .move(d_mv), .updown(d_ud),
        .load(d_ld), .load_val(d_lv), .q(d_q), .at_min(d_amin), .at_max(d_amax),
        .frame_tick(d_tick), .moved(d_moved)
    );

    axis_pos_counter #(.STEP(2), .FRAME_DIV(1), .SPEED_DIV(1), .WRAP(0)) u_sat (
        .clk(clk), .resetn(resetn), .enable(t_en), .move(t_mv), .updown(t_ud),
        .load(t_ld), .load_val(t_lv), .q(s_q), .at_min(s_amin), .at_max(s_amax),
        .frame_tick(s_tick), .moved(s_moved)
    );

    axis_pos_counter #(.STEP(1), .FRAME_DIV(1), .SPEED_DIV(1), .WRAP(1)) u_wrap (
        .clk(clk), .resetn(resetn), .enable(t_en), .move(t_mv), .updown(t_ud),
        .load(t_ld), .load_val(t_lv), .q(w_q), .at_min(w_amin), .at_max(w_amax),
        .frame_tick(w_tick), .moved(w_moved)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard of post-edge expectations
    typedef struct {
        int    inst;
        string nm;
        int    q;
        int    moved;
    } exp_t;
    exp_t sb[$];

    task automatic sb_push(input int inst, input string nm, input int q, input int mv);
        exp_t e;
        e.inst = inst; e.nm = nm; e.q = q; e.moved = mv;
        sb.push_back(e);
    endtask

    task automatic sb_pop_all();
        exp_t e;
        int aq, am, amin, amax;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.inst)
                0: begin aq = d_q; am = d_moved; amin = d_amin; amax = d_amax; end
                1: begin aq = s_q; am = s_moved; amin = s_amin; amax = s_amax; end
                default: begin aq = w_q; am = w_moved; amin = w_amin; amax = w_amax; end
            endcase
            chk({e.nm, "_q"}, aq, e.q);
            chk({e.nm, "_moved"}, am, e.moved);
            chk({e.nm, "_at_min"}, amin, (e.q == 0) ? 1 : 0);
            chk({e.nm, "_at_max"}, amax, (e.q == 155) ? 1 : 0);
        end
    endtask

    // Reference for the default instance
    int ecnt = 0;   // enabled cycles since reset
    int mq   = 0;
    bit last_tick;

    task automatic dcyc(input bit en, input bit mv, input bit ud, input bit ld, input int lv);
        bit exp_tick, slot;
        int nq, nmv;
        d_en = en; d_mv = mv; d_ud = ud; d_ld = ld; d_lv = 8'(lv);
        #3;
        exp_tick  = en && (ecnt % 10 == 9);
        slot      = exp_tick && (ecnt % 50 == 49);
        last_tick = d_tick;
        chk("d_frame_tick", d_tick, exp_tick);
        if (ld) begin
            nq  = (lv > 155) ? 155 : lv;
            nmv = 0;
        end else if (slot && mv) begin
            if (ud) nq = (mq + 1 > 155) ? 155 : mq + 1;
            else    nq = (mq >= 1) ? mq - 1 : 0;
            nmv = (nq != mq) ? 1 : 0;
        end else begin
            nq  = mq;
            nmv = 0;
        end
        mq = nq;
        if (en) ecnt++;
        sb_push(0, "d", nq, nmv);
        @(posedge clk);
        #1;
        sb_pop_all();
    endtask

    typedef struct {
        bit en, mv, ud, ld;
        int lv;
        int sq, sm;     // STEP 2 saturating expectation
        int wq, wm;     // STEP 1 wrapping expectation
    } vec_t;

    vec_t tbl[14];

    initial begin
        int k, ticks;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 200, 155, 0, 155, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0,   0, 155, 0,   0, 1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,   0, 153, 1, 155, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 154, 154, 0, 154, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0,   0, 155, 1, 155, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0,   0, 155, 0,   0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1,   1,   1, 0,   1, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0,   0,   0, 1,   0, 1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,   0,   0, 0, 155, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0,   0,   0, 0, 155, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1,   7,   7, 0,   7, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0,   0,   7, 0,   7, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0,   0,   9, 1,   8, 1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1,   0,   0, 0,   0, 0};

        resetn = 1'b0;
        d_en = 1'b0; d_mv = 1'b0; d_ud = 1'b0; d_ld = 1'b0; d_lv = 8'd0;
        t_en = 1'b0; t_mv = 1'b0; t_ud = 1'b0; t_ld = 1'b0; t_lv = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_q", d_q, 0);
        chk("rst_d_moved", d_moved, 0);
        chk("rst_d_tick", d_tick, 0);
        chk("rst_d_at_min", d_amin, 1);
        chk("rst_d_at_max", d_amax, 0);
        chk("rst_s_q", s_q, 0);
        chk("rst_w_q", w_q, 0);
        resetn = 1'b1;

        // Step-every-cycle instances: saturation, wrap, load priority, clamp
        for (int i = 0; i < 14; i++) begin
            t_en = tbl[i].en; t_mv = tbl[i].mv; t_ud = tbl[i].ud;
            t_ld = tbl[i].ld; t_lv = 8'(tbl[i].lv);
            #3;
            chk($sformatf("row%0d_sat_tick", i), s_tick, tbl[i].en);
            chk($sformatf("row%0d_wrap_tick", i), w_tick, tbl[i].en);
            sb_push(1, $sformatf("row%0d_sat", i), tbl[i].sq, tbl[i].sm);
            sb_push(2, $sformatf("row%0d_wrap", i), tbl[i].wq, tbl[i].wm);
            @(posedge clk);
            #1;
            sb_pop_all();
        end
        t_en = 1'b0; t_ld = 1'b0;

        // Cadence: tick every 10 enabled cycles, step every 50
        repeat (50) dcyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
        chk("cadence_q_after_50", d_q, 1);
        chk("cadence_moved_after_50", d_moved, 1);
        repeat (50) dcyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
        chk("cadence_q_after_100", d_q, 2);

        // Load clamp, then load on a step slot with move set
        dcyc(1'b1, 1'b1, 1'b1, 1'b1, 200);
        chk("load_clamp_q", d_q, 155);
        k = 0;
        while ((ecnt % 50 != 49) && k < 100) begin
            dcyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
            k++;
        end
        dcyc(1'b1, 1'b1, 1'b1, 1'b1, 7);
        chk("load_on_slot_q", d_q, 7);
        chk("load_on_slot_moved", d_moved, 0);
        k = 0;
        do begin
            dcyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
            k++;
        end while (!d_moved && k < 60);
        chk("load_phase_slot_gap", k, 50);

        // Enable freeze with the frame divider at 4
        repeat (4) dcyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
        ticks = 0;
        repeat (23) begin
            dcyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
            ticks += int'(last_tick);
        end
        chk("freeze_ticks", ticks, 0);
        k = 0;
        do begin
            dcyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
            k++;
        end while (!last_tick && k < 20);
        chk("resume_tick_gap", k, 6);

        // Asynchronous reset mid-operation with q = 40 and moved high
        dcyc(1'b1, 1'b0, 1'b1, 1'b1, 39);
        k = 0;
        do begin
            dcyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
            k++;
        end while (!d_moved && k < 60);
        chk("pre_reset_q", d_q, 40);
        chk("pre_reset_moved", d_moved, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_q", d_q, 0);
        chk("async_rst_moved", d_moved, 0);
        chk("async_rst_tick", d_tick, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ecnt = 0;
        mq   = 0;

        // Reset while frame_tick is high must drop it at once
        repeat (9) dcyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
        #2;
        chk("pre_reset_tick", d_tick, 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_tick_drop", d_tick, 0);
        chk("async_rst_q2", d_q, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
